// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word reads and buffers returned words in a 2-entry queue.
// Optional misaligned-redirect fault detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_en,
    output logic                          imem_en,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_rdata,
    input  logic                          pc_select,
    input  logic [31:0]                   branch_target,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   instr,
    output logic [31:0]                   inst_pc,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic [6:0]                    funct7,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                          fetch_fault,
`endif
    output logic [4:0]                    rs2
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] infl_pc_q;
    logic        inflight_q;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];

    logic       pop, push, issue, flush, misalign;
    logic [2:0] occupancy;

    always_comb begin
        misalign = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign = pc_select && (branch_target[1:0] != 2'b00);
`endif
        pop       = inst_valid && inst_ready;
        // Slots already committed once this cycle's pop is taken into account.
        occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == StRun) && fetch_en && !pc_select && (occupancy < 3'd2);
        // A redirect in IDLE only moves the PC; a misaligned one always faults.
        flush     = (pc_select && (state_q == StRun)) || misalign;
        push      = inflight_q && !flush;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (fetch_en) state_d = StRun;
            StRun:   if (!fetch_en) state_d = StIdle;
            StFault: state_d = StFault;
            default: state_d = StIdle;
        endcase
        if (misalign) state_d = StFault;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (state_q != StFault) begin
            if (misalign) begin
                fetch_pc_d = branch_target;
            end else if (pc_select) begin
                fetch_pc_d = branch_target & 32'hFFFF_FFFC;
            end else if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            infl_pc_q  <= 32'd0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= issue;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (issue) infl_pc_q <= fetch_pc_q;
        end
    end

    // Storage has no reset; stale contents are masked by inst_valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[wr_ptr_q] <= imem_rdata;
            q_pc[wr_ptr_q]    <= infl_pc_q;
        end
    end

    assign imem_en    = issue;
    assign imem_addr  = fetch_pc_q[2 +: AW];
    assign inst_valid = (count_q != 2'd0);
    assign instr      = q_instr[rd_ptr_q];
    assign inst_pc    = q_pc[rd_ptr_q];
    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];
    assign rd         = instr[11:7];
    assign rs1        = instr[19:15];
    assign rs2        = instr[24:20];

`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state_q == StFault);
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the RV32V core. It owns the fetch PC, issues word reads to the synchronous instruction memory, and buffers returned words in a 2-entry queue. It presents one instruction at a time, with split opcode/funct3/funct7/register fields, to the decode/control stage under a valid/ready handshake. It also redirects the PC when decode raises `pc_select`.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two.
- `RESET_PC`, 32'h0000_0000: fetch PC after reset; word aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_en` in 1: permits new memory reads.
- `imem_en` out 1: read strobe to instruction memory.
- `imem_addr` out log2(IMEM_DEPTH): word address, equal to `fetch_pc[2 +: log2(IMEM_DEPTH)]`.
- `imem_rdata` in 32: read data, valid exactly 1 cycle after `imem_en`.
- `pc_select` in 1: redirect request from decode.
- `branch_target` in 32: redirect PC.
- `inst_valid` out 1: head of queue valid.
- `inst_ready` in 1: decode accepts the head.
- `instr` out 32: head instruction word.
- `inst_pc` out 32: PC of the head instruction.
- `opcode` out 7, `funct3` out 3, `funct7` out 7, `rd` out 5, `rs1` out 5, `rs2` out 5: fields of `instr` at bits [6:0], [14:12], [31:25], [11:7], [19:15] and [24:20].
- `fetch_fault` out 1: misaligned redirect flag, present only with the macro enabled.

## Operation
- State machine with three states, reset to IDLE:
  - IDLE -> RUN when `fetch_en`=1.
  - RUN -> IDLE when `fetch_en`=0.
  - Any state -> FAULT on a misaligned redirect (macro only). FAULT is left only by `rst`.
- Issue rule: in RUN, `imem_en`=1 when (count + inflight − pop) < 2. Each issue latches the PC into `infl_pc`, advances `fetch_pc` by 4, and sets `inflight`=1 for one cycle.
- PC wrap: `fetch_pc` is 32-bit and wraps modulo 2^32. `imem_addr` wraps modulo `IMEM_DEPTH`.
- Response: in the cycle after an issue, {`imem_rdata`, `infl_pc`} is written to the queue at the next edge, unless flushed.
- Queue: 2 entries with a 2-bit count (0..2) and 1-bit read/write pointers.
  - Pop when `inst_valid` and `inst_ready` are both 1.
  - Push and pop in the same cycle leaves the count unchanged.
  - The issue rule guarantees no push when full.
  - No pop when empty; `inst_ready` is a don't-care while `inst_valid`=0.
- Outputs are driven from the head entry. `inst_valid` is 1 when count > 0. Field outputs are combinational slices of `instr`.
- Redirect: `pc_select`=1 has top priority.
  - At the edge: `fetch_pc` <= {`branch_target`[31:2], 2'b00}, the queue is cleared, and any response arriving this cycle is dropped.
  - No issue occurs in the redirect cycle.
  - A simultaneous pop of the head is still counted as accepted.
- Redirect in IDLE updates `fetch_pc` only.
- `fetch_en`=0 stops new issues. An in-flight response still lands and the queue still drains.
- Reset values:
  - State IDLE, `fetch_pc`=`RESET_PC`, count 0, pointers 0, `inflight`=0.
  - Outputs: `imem_en`=0, `inst_valid`=0, `fetch_fault`=0.
  - `instr`/`inst_pc` show the stale entry 0 and must not be relied on.

## Timing
- Throughput: 1 instruction/cycle with `inst_ready` held at 1.
- Latency: issue at edge Ei, data present in cycle i+1, written at Ei+1, `inst_valid`=1 after Ei+1.
- From reset release with `fetch_en`=1: E0 moves to RUN; `imem_en`=1 with address `RESET_PC` during cycle 1; first `inst_valid` after E2.
- Redirect at edge Er: `inst_valid`=0 in cycle r+1, `imem_en`=1 at the target in cycle r+1, target instruction valid after Er+2.
- `rst` in any cycle overrides redirect, push, pop and issue. An in-flight response is discarded.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `branch_target`[1:0] ≠ 0 sets `fetch_fault`=1 (sticky), clears the queue, and enters FAULT.
  - In FAULT there are no issues and `inst_valid`=0.
  - `fetch_pc` holds the raw misaligned target for debug.
- Not defined:
  - `fetch_fault` port is absent.
  - Target bits [1:0] are forced to 0, and FAULT is unreachable.

## Test plan
- Reset, `fetch_en`=1, `inst_ready`=1, memory word k = 32'h0000_0013 + (k<<20): `inst_pc` 0,4,8,… on consecutive cycles from cycle 3; `opcode`=19; `rs2` equals k[4:0].
- Backpressure: `inst_ready`=0 for 5 cycles → count saturates at 2, exactly 2 issues total, `imem_en`=0 while full; on release, PCs in order with no gap or duplicate.
- Redirect with `pc_select`=1, `branch_target`=32'h40 while the queue is full and one read is in flight → next valid `inst_pc`=32'h40 two edges later; the old PCs never appear.
- Wrap with `IMEM_DEPTH`=64 and PC reaching 32'hFC → next `imem_addr`=0, `inst_pc`=32'h100.
- `fetch_en` dropped mid-stream → at most 1 further push, and the queue drains fully.
- Macro on, `branch_target`=32'h42 → `fetch_fault`=1 next cycle, `inst_valid`=0 forever, `imem_en`=0 until `rst`. Macro off, same stimulus → fetch resumes at 32'h40.
